// File: rtl/stage_me_pkg.sv
// Shared definitions for the RV32I memory stage: load/store width codes,
// FSM state encodings and the access-legality check.
package stage_me_pkg;

   typedef logic [2:0] ls_code_t;

   localparam ls_code_t LS_B  = 3'b000;
   localparam ls_code_t LS_H  = 3'b001;
   localparam ls_code_t LS_W  = 3'b010;
   localparam ls_code_t LS_BU = 3'b100;
   localparam ls_code_t LS_HU = 3'b101;

   localparam logic [0:0] ME_IDLE   = 1'b0;
   localparam logic [0:0] ME_ACCESS = 1'b1;

   // Unsigned widths only exist for loads; any unlisted code is illegal.
   function automatic logic ls_misalign(input ls_code_t code,
                                        input logic [1:0] addr_lo,
                                        input logic is_store);
      logic bad;
      case (code)
         LS_B:    bad = 1'b0;
         LS_H:    bad = addr_lo[0];
         LS_W:    bad = (addr_lo != 2'b00);
         LS_BU:   bad = is_store;
         LS_HU:   bad = is_store | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/stage_me_if.sv
// Data-memory req/ack bus between the memory stage (master) and the
// data memory (slave).
interface stage_me_if #(parameter int XLEN = 32);

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_be;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/stage_me_lsu_align.sv
// Combinational load/store lane logic: store byte enables and lane
// replication, load byte/half extraction with sign/zero extension.
module stage_me_lsu_align
   import stage_me_pkg::*;
(
   input  ls_code_t    func3,
   input  logic [1:0]  addr_lo,
   input  logic        is_store,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misalign
);

   logic [7:0]         byte_u;
   logic [15:0]        half_u;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   assign misalign = ls_misalign(func3, addr_lo, is_store);

   always_comb begin
      be    = 4'b1111;
      wdata = sdata;
      if (is_store) begin
         case (func3)
            LS_B: begin
               be    = 4'b0001 << addr_lo;
               wdata = {4{sdata[7:0]}};
            end
            LS_H: begin
               be    = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata = {2{sdata[15:0]}};
            end
            default: begin
               be    = 4'b1111;
               wdata = sdata;
            end
         endcase
      end
   end

   always_comb begin
      case (addr_lo)
         2'd0:    byte_u = rdata[7:0];
         2'd1:    byte_u = rdata[15:8];
         2'd2:    byte_u = rdata[23:16];
         default: byte_u = rdata[31:24];
      endcase
      half_u = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      byte_s = $signed(byte_u);
      half_s = $signed(half_u);
      case (func3)
         LS_B:    ld_data = 32'(byte_s);
         LS_BU:   ld_data = {24'd0, byte_u};
         LS_H:    ld_data = 32'(half_s);
         LS_HU:   ld_data = {16'd0, half_u};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_me.sv
// RV32I memory stage: EX/ME register, req/ack data-memory FSM, load alignment.
// Optional ack watchdog enabled by defining STAGE_ME_TIMEOUT_EN.
module stage_me
   import stage_me_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] ex_alu_o,
   input  logic [XLEN-1:0] ex_regs_data2_o,
   input  ls_code_t        ex_func3_code,
   input  logic            ex_mem_rd,
   input  logic            ex_mem_wr,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_wr,
   input  logic            ex_valid,
   output logic            me_stall,
   output logic [XLEN-1:0] me_alu_o,
   output logic [XLEN-1:0] me_mem_data,
   output logic [4:0]      me_rd,
   output logic            me_reg_wr,
   output logic            me_valid,
   output logic            me_misalign,
   output logic            me_bus_err,
   stage_me_if.master      dmem
);

   if (XLEN != 32 || TIMEOUT < 1) begin : g_param_chk
      $error("stage_me: only XLEN=32 and TIMEOUT>=1 are supported");
   end

   logic [0:0]      state_q;
   logic [XLEN-1:0] alu_p0;
   logic [XLEN-1:0] sdata_p0;
   ls_code_t        func3_p0;
   logic            mem_rd_p0;
   logic            mem_wr_p0;
   logic [4:0]      rd_p0;
   logic            reg_wr_p0;
   logic            vld_p0;

   logic            capture;
   logic            ex_go;
   logic            access;
   logic            done;
   logic            timeout_hit;
   logic            is_mem_p0;
   logic            lsu_misalign;
   logic [XLEN-1:0] ld_data;

   // An aligned memory op enters ACCESS straight from capture, so the
   // FSM never needs to look at the held registers to leave IDLE.
   assign ex_go = ex_valid && (ex_mem_rd || ex_mem_wr)
                  && !ls_misalign(ex_func3_code, ex_alu_o[1:0], ex_mem_wr);

   assign access    = (state_q == ME_ACCESS);
   assign done      = access && (dmem.dmem_ack || timeout_hit);
   assign me_stall  = access && !done;
   assign capture   = !me_stall;
   assign is_mem_p0 = vld_p0 && (mem_rd_p0 || mem_wr_p0);

   // ---- EX/ME boundary ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ME_IDLE;
         alu_p0    <= '0;
         sdata_p0  <= '0;
         func3_p0  <= LS_B;
         mem_rd_p0 <= 1'b0;
         mem_wr_p0 <= 1'b0;
         rd_p0     <= '0;
         reg_wr_p0 <= 1'b0;
         vld_p0    <= 1'b0;
      end else if (capture) begin
         state_q   <= ex_go ? ME_ACCESS : ME_IDLE;
         alu_p0    <= ex_alu_o;
         sdata_p0  <= ex_regs_data2_o;
         func3_p0  <= ex_func3_code;
         mem_rd_p0 <= ex_mem_rd;
         mem_wr_p0 <= ex_mem_wr;
         rd_p0     <= ex_rd;
         reg_wr_p0 <= ex_valid && ex_reg_wr;
         vld_p0    <= ex_valid;
      end
   end

`ifdef STAGE_ME_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] wd_cnt_q;

   assign timeout_hit = access && !dmem.dmem_ack && (wd_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || capture) wd_cnt_q <= '0;
      else if (access)       wd_cnt_q <= wd_cnt_q + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   stage_me_lsu_align u_lsu (
      .func3    (func3_p0),
      .addr_lo  (alu_p0[1:0]),
      .is_store (mem_wr_p0),
      .sdata    (sdata_p0),
      .rdata    (dmem.dmem_rdata),
      .be       (dmem.dmem_be),
      .wdata    (dmem.dmem_wdata),
      .ld_data  (ld_data),
      .misalign (lsu_misalign)
   );

   assign dmem.dmem_req  = access;
   assign dmem.dmem_we   = mem_wr_p0;
   assign dmem.dmem_addr = {alu_p0[XLEN-1:2], 2'b00};

   assign me_alu_o    = alu_p0;
   assign me_rd       = rd_p0;
   assign me_bus_err  = timeout_hit;
   assign me_misalign = is_mem_p0 && lsu_misalign;
   assign me_valid    = done || (vld_p0 && !is_mem_p0) || me_misalign;
   assign me_reg_wr   = me_valid && reg_wr_p0 && !me_misalign && !me_bus_err;
   assign me_mem_data = (done && mem_rd_p0 && !timeout_hit) ? ld_data : '0;

endmodule

// File: doc/stage_me.md
Name: stage_me

Overview:
- Memory stage of the 5-stage RV32I core; sits directly downstream of the execute stage.
- Registers the EX results (EX/ME pipeline register).
- Runs loads and stores to data memory over a req/ack handshake, aligning and sign/zero-extending load data.
- Drives me_alu_o back to the EX forwarding muxes and asserts me_stall while a memory access is pending.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT, 255, watchdog limit in cycles for dmem_ack (used only with STAGE_ME_TIMEOUT_EN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- ex_alu_o  in  32  ALU result / effective address
- ex_regs_data2_o  in  32  forwarded store data
- ex_func3_code  in  3  load/store width code
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store
- ex_rd  in  5  destination register
- ex_reg_wr  in  1  writes rd
- ex_valid  in  1  EX holds a real instruction
- me_stall  out  1  freeze IF/ID/EX and hold inputs stable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits[1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; read data valid this cycle
- dmem_rdata  in  32  raw read word
- me_alu_o  out  32  registered ALU result (forwarding source)
- me_mem_data  out  32  aligned, extended load result
- me_rd  out  5  registered rd
- me_reg_wr  out  1  registered write enable, qualified
- me_valid  out  1  instruction completes to WB
- me_misalign  out  1  misaligned or illegal-width access
- me_bus_err  out  1  ack timeout; constant 0 without the macro

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all registered outputs are 0; dmem_req=0; me_stall=0.
- Capture: on posedge with me_stall=0, latch all ex_* inputs. A bubble (ex_valid=0) captures me_valid=0 and me_reg_wr=0.
- States are IDLE and ACCESS.
  - IDLE → ACCESS when a captured valid memory op is aligned.
  - ACCESS → IDLE on dmem_ack, unless a new aligned memory op is captured in the same cycle; then stay in ACCESS.
- Request signals:
  - dmem_req = (state==ACCESS).
  - dmem_addr/we/be/wdata are derived from the held registers and stay stable until ack.
- Stall: me_stall = (state==ACCESS) && !dmem_ack. Capture is therefore allowed in the ack cycle.
- Latency:
  - Non-memory op: me_valid one cycle after capture.
  - Memory op: me_valid in the cycle of dmem_ack (combinational from state+ack, registered data path). Zero-wait ack gives 1-cycle latency.
- Load data: me_mem_data is valid when me_valid=1.
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], extended.
  - LW: full word.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata = byte replicated x4.
  - SH: be=0011 or 1100, wdata = half replicated x2.
  - SW: be=1111.
  - For loads, dmem_be=1111.
- func3 codes: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU on a store, or any other code, is illegal.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0; or an illegal code.
  - No request is issued.
  - me_valid=1 and me_misalign=1 for one cycle.
  - me_reg_wr forced to 0.
- me_alu_o updates on every capture regardless of op type.
- Reset mid-ACCESS: the access is abandoned and dmem_req drops the next cycle. The memory side ignores the orphaned ack.

Optional Feature:
- Macro STAGE_ME_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter runs in ACCESS and clears on entry.
  - Counter reaching TIMEOUT without ack forces IDLE, asserts me_valid and me_bus_err for one cycle, and forces me_reg_wr=0.
  - A later stray ack is ignored.
- Undefined: no counter; ACCESS waits indefinitely; me_bus_err tied 0.

Decomposition:
- define.v holds: LS width codes (LS_B, LS_H, LS_W, LS_BU, LS_HU) and state encodings ME_IDLE/ME_ACCESS.
- Sub-module lsu_align, purely combinational: store be/wdata generation, load extract/extend, misalign detect.
- stage_me keeps the pipeline register, FSM and optional watchdog.

Test Plan:
- ALU op 0x0000_1234, rd=5, no mem → next cycle me_alu_o=0x1234, me_rd=5, me_reg_wr=1, me_valid=1, no dmem_req.
- LB addr 0x103, dmem_rdata 0x80FF_0000, ack after 3 cycles → me_stall high 3 cycles, dmem_addr=0x100, me_mem_data=0xFFFF_FF80.
- LHU addr 0x102, rdata 0x8001_0000, zero-wait ack → me_mem_data=0x0000_8001, no stall cycle.
- SB addr 0x201 data 0x0000_00AB → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1, me_reg_wr=0.
- LW addr 0x102 → no dmem_req, me_misalign=1, me_reg_wr=0; back-to-back load captured in the ack cycle proceeds without a bubble.
- With STAGE_ME_TIMEOUT_EN and TIMEOUT=4, ack withheld → me_bus_err pulses after 4 ACCESS cycles and the FSM returns to IDLE.
